// File: rtl/kernel_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kernel_run_ctrl
// Description : Run sequencer for one HLS kernel on the ap_ctrl_hs handshake.
//               Relaunches the kernel while run_en is high, with a
//               programmable idle gap after each ap_done. Rotates a dataset
//               index every UPDATE_INV completed runs, and stops a hung
//               kernel with a watchdog.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro : RUN_CTRL_PROFILE_EN
//   defined   -> last_lat / max_lat report measured run latency
//   undefined -> last_lat / max_lat are tied to 0
// ----------------------------------------------------------------------------
// Ports
//   ap_clk       in   1      single clock
//   ap_rst       in   1      synchronous active-high reset
//   run_en       in   1      level, keep launching runs (already synchronised)
//   ap_start     out  1      kernel start, held until ap_ready / ap_done
//   ap_done      in   1      kernel done pulse
//   ap_ready     in   1      kernel input-accepted pulse
//   ap_idle      in   1      kernel idle, gates IDLE -> START only
//   dataset_idx  out  IDX_W  current dataset selection
//   dataset_swap out  1      pulse in the cycle dataset_idx changes
//   run_cnt      out  32     completed runs since reset (wraps)
//   busy         out  1      high in START, WAIT_DONE and GAP
//   timeout_err  out  1      sticky watchdog flag, cleared by run_en = 0
//   last_lat     out  32     latency of the last completed run (profile)
//   max_lat      out  32     running maximum of last_lat (profile)
// ============================================================================
module kernel_run_ctrl #(
    parameter int DATASET_NUM    = 8,
    parameter int UPDATE_INV     = 1,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int IDX_W          = 3
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             run_en,
    output logic             ap_start,
    input  logic             ap_done,
    input  logic             ap_ready,
    input  logic             ap_idle,
    output logic [IDX_W-1:0] dataset_idx,
    output logic             dataset_swap,
    output logic [31:0]      run_cnt,
    output logic             busy,
    output logic             timeout_err,
    output logic [31:0]      last_lat,
    output logic [31:0]      max_lat
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_wait  = 3'd2;
    localparam logic [2:0] c_st_gap   = 3'd3;
    localparam logic [2:0] c_st_err   = 3'd4;

    // A zero gap still spends one cycle in GAP, so the load saturates at 0.
    localparam logic [31:0] c_gap_load = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
    localparam logic [31:0] c_wd_limit = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] c_upd_last = 32'(UPDATE_INV - 1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(DATASET_NUM - 1);

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    logic [2:0]       r_state;
    logic             r_ap_start;
    logic             r_busy;
    logic             r_err;
    logic [IDX_W-1:0] r_idx;
    logic             r_swap;
    logic [31:0]      r_run_cnt;
    logic [31:0]      r_ds_runs;
    logic [31:0]      r_gap;
    logic [31:0]      r_wd;

    logic             w_complete;
    logic             w_wd_hit;
    logic             w_rotate;
    logic [IDX_W-1:0] w_idx_next;

    // ap_done while still in START (with or without ap_ready) finishes the run.
    assign w_complete = ((r_state == c_st_start) || (r_state == c_st_wait)) && ap_done;
    assign w_wd_hit   = (r_wd == c_wd_limit);
    assign w_rotate   = w_complete && (r_ds_runs == c_upd_last);
    // Explicit compare-and-wrap keeps non power-of-two dataset counts correct.
    assign w_idx_next = (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state    <= c_st_idle;
            r_ap_start <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_idx      <= '0;
            r_swap     <= 1'b0;
            r_run_cnt  <= '0;
            r_ds_runs  <= '0;
            r_gap      <= '0;
            r_wd       <= '0;
        end else begin
            r_swap <= 1'b0;

            // Run accounting happens on the edge that enters GAP, so the new
            // dataset index and the swap pulse appear in the first GAP cycle,
            // never while ap_start is high or the kernel is running.
            if (w_complete) begin
                r_run_cnt <= r_run_cnt + 32'd1;
                if (w_rotate) begin
                    r_ds_runs <= '0;
                    r_idx     <= w_idx_next;
                    r_swap    <= 1'b1;
                end else begin
                    r_ds_runs <= r_ds_runs + 32'd1;
                end
            end

            case (r_state)
                c_st_idle: begin
                    if (run_en && ap_idle && !r_err) begin
                        r_state    <= c_st_start;
                        r_ap_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_wd       <= '0;
                    end
                end

                c_st_start: begin
                    r_wd <= r_wd + 32'd1;
                    if (ap_done) begin
                        r_state    <= c_st_gap;
                        r_ap_start <= 1'b0;
                        r_gap      <= c_gap_load;
                    end else if (w_wd_hit) begin
                        r_state    <= c_st_err;
                        r_ap_start <= 1'b0;
                        r_busy     <= 1'b0;
                        r_err      <= 1'b1;
                    end else if (ap_ready) begin
                        r_state    <= c_st_wait;
                        r_ap_start <= 1'b0;
                    end
                end

                c_st_wait: begin
                    r_wd <= r_wd + 32'd1;
                    // Done takes priority over a watchdog hit in the same cycle.
                    if (ap_done) begin
                        r_state <= c_st_gap;
                        r_gap   <= c_gap_load;
                    end else if (w_wd_hit) begin
                        r_state <= c_st_err;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end
                end

                c_st_gap: begin
                    if (r_gap == 32'd0) begin
                        if (run_en) begin
                            r_state    <= c_st_start;
                            r_ap_start <= 1'b1;
                            r_wd       <= '0;
                        end else begin
                            r_state <= c_st_idle;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_gap <= r_gap - 32'd1;
                    end
                end

                c_st_err: begin
                    // Software acknowledges the timeout by dropping run_en.
                    if (!run_en) begin
                        r_state <= c_st_idle;
                        r_err   <= 1'b0;
                    end
                end

                default: begin
                    r_state    <= c_st_idle;
                    r_ap_start <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign ap_start     = r_ap_start;
    assign busy         = r_busy;
    assign timeout_err  = r_err;
    assign dataset_idx  = r_idx;
    assign dataset_swap = r_swap;
    assign run_cnt      = r_run_cnt;

    // ------------------------------------------------------------------------
    // Optional latency profiling
    // ------------------------------------------------------------------------
`ifdef RUN_CTRL_PROFILE_EN
    logic [31:0] r_last_lat;
    logic [31:0] r_max_lat;
    logic [31:0] w_run_lat;

    // r_wd is 0 in the first ap_start cycle, so +1 counts both end cycles.
    assign w_run_lat = r_wd + 32'd1;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_last_lat <= '0;
            r_max_lat  <= '0;
        end else if (w_complete) begin
            r_last_lat <= w_run_lat;
            if (w_run_lat > r_max_lat) begin
                r_max_lat <= w_run_lat;
            end
        end
    end

    assign last_lat = r_last_lat;
    assign max_lat  = r_max_lat;
`else
    assign last_lat = '0;
    assign max_lat  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_kernel_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_kernel_run_ctrl
// Description : Directed self-checking bench for kernel_run_ctrl with a
//               behavioural ap_ctrl_hs kernel model.
//               DUT: DATASET_NUM=3, UPDATE_INV=2, GAP_CYCLES=4,
//               TIMEOUT_CYCLES=64. Cycle 0 of a run is the first cycle in
//               which ap_start is seen high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kernel_run_ctrl;

`ifdef RUN_CTRL_PROFILE_EN
    localparam bit c_prof = 1'b1;
`else
    localparam bit c_prof = 1'b0;
`endif

    logic        clk;
    logic        ap_rst;
    logic        run_en;
    logic        ap_start;
    logic        ap_done;
    logic        ap_ready;
    logic        ap_idle;
    logic [1:0]  dataset_idx;
    logic        dataset_swap;
    logic [31:0] run_cnt;
    logic        busy;
    logic        timeout_err;
    logic [31:0] last_lat;
    logic [31:0] max_lat;

    int n_tests = 0;
    int n_fail  = 0;

    // kernel model controls
    int k_ready_at = 1;
    int k_done_at  = 9;
    bit k_hang     = 1'b0;
    bit k_active   = 1'b0;
    int k_cnt      = 0;

    kernel_run_ctrl #(
        .DATASET_NUM   (3),
        .UPDATE_INV    (2),
        .GAP_CYCLES    (4),
        .TIMEOUT_CYCLES(64),
        .IDX_W         (2)
    ) dut (
        .ap_clk      (clk),
        .ap_rst      (ap_rst),
        .run_en      (run_en),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_ready    (ap_ready),
        .ap_idle     (ap_idle),
        .dataset_idx (dataset_idx),
        .dataset_swap(dataset_swap),
        .run_cnt     (run_cnt),
        .busy        (busy),
        .timeout_err (timeout_err),
        .last_lat    (last_lat),
        .max_lat     (max_lat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Kernel model: ready in cycle k_ready_at, done in cycle k_done_at of a run.
    initial begin
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        ap_idle  = 1'b1;
        forever begin
            @(negedge clk);
            ap_ready = 1'b0;
            ap_done  = 1'b0;
            if (ap_rst || timeout_err) begin
                k_active = 1'b0;
            end else if (!k_active) begin
                if (ap_start) begin
                    k_active = 1'b1;
                    k_cnt    = 0;
                end
            end else begin
                k_cnt++;
            end
            if (k_active) begin
                if (k_cnt == k_ready_at) ap_ready = 1'b1;
                if (!k_hang && k_cnt == k_done_at) begin
                    ap_done  = 1'b1;
                    k_active = 1'b0;
                end
            end
            ap_idle = !k_active;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        ap_rst = 1'b1;
        run_en = 1'b0;
        repeat (3) tick();
        ap_rst = 1'b0;
        tick();
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ap_start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic set_kernel(input int rdy, input int dn, input bit hang);
        k_ready_at = rdy;
        k_done_at  = dn;
        k_hang     = hang;
    endtask

    task automatic test_reset;
        ap_rst = 1'b1;
        run_en = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({ap_start, busy, dataset_swap, timeout_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {ap_start, busy, dataset_swap, timeout_err});
        end
        n_tests++;
        if (run_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_run_cnt: got %0d expected 0", run_cnt);
        end
        n_tests++;
        if (dataset_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_idx: got %0d expected 0", dataset_idx);
        end
        n_tests++;
        if ({last_lat, max_lat} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_lat: got %0d/%0d expected 0/0", last_lat, max_lat);
        end
        ap_rst = 1'b0;
        run_en = 1'b0;
        tick();
    endtask

    task automatic test_single_run;
        bit ok;
        int first_low = -1, cnt_c = -1, restart_c = -1, busy_bad = 0;
        do_reset();
        set_kernel(1, 9, 1'b0);
        run_en = 1'b1;
        wait_start(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_start: got no ap_start expected ap_start within 50 cycles");
        end
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (first_low < 0 && !ap_start) first_low = c;
            if (cnt_c < 0 && run_cnt == 32'd1) cnt_c = c;
            if (first_low > 0 && restart_c < 0 && ap_start) restart_c = c;
            if (c < 14 && !busy) busy_bad++;
        end
        n_tests++;
        if (first_low !== 2) begin
            n_fail++;
            $display("FAIL single_start_width: got %0d expected 2", first_low);
        end
        n_tests++;
        if (cnt_c !== 10) begin
            n_fail++;
            $display("FAIL single_run_cnt_cycle: got %0d expected 10", cnt_c);
        end
        n_tests++;
        if (restart_c !== 14) begin
            n_fail++;
            $display("FAIL single_restart_cycle: got %0d expected 14", restart_c);
        end
        n_tests++;
        if (busy_bad !== 0) begin
            n_fail++;
            $display("FAIL single_busy: got %0d idle cycles expected 0", busy_bad);
        end
        n_tests++;
        if (run_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL single_run_cnt_end: got %0d expected 2", run_cnt);
        end
        n_tests++;
        if (last_lat !== (c_prof ? 32'd10 : 32'd0) || max_lat !== (c_prof ? 32'd10 : 32'd0)) begin
            n_fail++;
            $display("FAIL single_lat: got %0d/%0d expected %0d", last_lat, max_lat, c_prof ? 10 : 0);
        end
        run_en = 1'b0;
    endtask

    task automatic test_rotation;
        int nsw = 0, bad = 0;
        logic [1:0] prev_idx = 2'd0;
        int sw_run [3];
        int sw_idx [3];
        int exp_run [3] = '{2, 4, 6};
        int exp_idx [3] = '{1, 2, 0};
        do_reset();
        set_kernel(1, 3, 1'b0);
        run_en = 1'b1;
        for (int c = 0; c < 200 && run_cnt != 32'd7; c++) begin
            tick();
            if (dataset_idx != prev_idx && (!dataset_swap || ap_start)) bad++;
            if (dataset_swap && dataset_idx == prev_idx) bad++;
            if (dataset_swap) begin
                if (nsw < 3) begin
                    sw_run[nsw] = int'(run_cnt);
                    sw_idx[nsw] = int'(dataset_idx);
                end
                nsw++;
            end
            prev_idx = dataset_idx;
        end
        run_en = 1'b0;
        n_tests++;
        if (run_cnt !== 32'd7) begin
            n_fail++;
            $display("FAIL rot_runs: got %0d expected 7", run_cnt);
        end
        n_tests++;
        if (nsw !== 3) begin
            n_fail++;
            $display("FAIL rot_swaps: got %0d expected 3", nsw);
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rot_illegal_change: got %0d expected 0", bad);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (nsw < 3 || sw_run[i] !== exp_run[i] || sw_idx[i] !== exp_idx[i]) begin
                n_fail++;
                $display("FAIL rot_swap%0d: got run %0d idx %0d expected run %0d idx %0d",
                         i, sw_run[i], sw_idx[i], exp_run[i], exp_idx[i]);
            end
        end
    endtask

    task automatic test_coincident;
        bit ok;
        bit restarted = 1'b0;
        do_reset();
        set_kernel(1, 1, 1'b0);
        run_en = 1'b1;
        wait_start(ok);
        tick();
        n_tests++;
        if (!ok || ap_start !== 1'b1) begin
            n_fail++;
            $display("FAIL coin_held: got %b expected 1", ap_start);
        end
        run_en = 1'b0;
        tick();
        n_tests++;
        if ({ap_start, busy} !== 2'b01 || run_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL coin_gap: got start/busy %b run_cnt %0d expected 01 and 1", {ap_start, busy}, run_cnt);
        end
        n_tests++;
        if (last_lat !== (c_prof ? 32'd2 : 32'd0)) begin
            n_fail++;
            $display("FAIL coin_lat: got %0d expected %0d", last_lat, c_prof ? 2 : 0);
        end
        repeat (10) begin
            tick();
            if (ap_start) restarted = 1'b1;
        end
        n_tests++;
        if (restarted || busy !== 1'b0 || run_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL coin_once: got restart %b busy %b run_cnt %0d expected 0 0 1", restarted, busy, run_cnt);
        end
    endtask

    task automatic test_done_no_ready;
        bit ok;
        do_reset();
        set_kernel(50, 2, 1'b0);
        run_en = 1'b1;
        wait_start(ok);
        run_en = 1'b0;
        repeat (2) tick();
        n_tests++;
        if (!ok || ap_start !== 1'b1) begin
            n_fail++;
            $display("FAIL dnr_held: got %b expected 1", ap_start);
        end
        tick();
        n_tests++;
        if (ap_start !== 1'b0 || run_cnt !== 32'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL dnr_done: got start %b run_cnt %0d busy %b expected 0 1 1", ap_start, run_cnt, busy);
        end
    endtask

    task automatic test_watchdog;
        bit ok;
        bit restarted = 1'b0;
        do_reset();
        set_kernel(1, 5, 1'b1);
        run_en = 1'b1;
        wait_start(ok);
        repeat (63) tick();
        n_tests++;
        if (!ok || {timeout_err, busy, ap_start} !== 3'b010) begin
            n_fail++;
            $display("FAIL wd_before: got %b expected 010", {timeout_err, busy, ap_start});
        end
        tick();
        n_tests++;
        if ({timeout_err, busy, ap_start} !== 3'b100) begin
            n_fail++;
            $display("FAIL wd_trip: got %b expected 100", {timeout_err, busy, ap_start});
        end
        repeat (10) begin
            tick();
            if (ap_start) restarted = 1'b1;
        end
        n_tests++;
        if (restarted || timeout_err !== 1'b1 || run_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL wd_sticky: got restart %b err %b run_cnt %0d expected 0 1 0", restarted, timeout_err, run_cnt);
        end
        run_en = 1'b0;
        tick();
        n_tests++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_clear: got %b expected 0", timeout_err);
        end
        set_kernel(1, 5, 1'b0);
        run_en = 1'b1;
        wait_start(ok);
        repeat (6) tick();
        run_en = 1'b0;
        n_tests++;
        if (!ok || run_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL wd_restart: got started %b run_cnt %0d expected 1 1", ok, run_cnt);
        end
    endtask

    task automatic test_wd_boundary;
        bit ok;
        do_reset();
        set_kernel(1, 63, 1'b0);
        run_en = 1'b1;
        wait_start(ok);
        run_en = 1'b0;
        repeat (64) tick();
        n_tests++;
        if (!ok || timeout_err !== 1'b0 || run_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL wd_done_wins: got err %b run_cnt %0d expected 0 1", timeout_err, run_cnt);
        end
        n_tests++;
        if (last_lat !== (c_prof ? 32'd64 : 32'd0)) begin
            n_fail++;
            $display("FAIL wd_done_lat: got %0d expected %0d", last_lat, c_prof ? 64 : 0);
        end
    endtask

    task automatic test_run_en_drop;
        bit ok;
        bit restarted = 1'b0;
        logic [31:0] cnt10 = '0;
        logic busy13 = 1'b0, busy14 = 1'b1;
        do_reset();
        set_kernel(1, 9, 1'b0);
        run_en = 1'b1;
        wait_start(ok);
        repeat (3) tick();
        run_en = 1'b0;
        for (int c = 4; c <= 40; c++) begin
            tick();
            if (ap_start) restarted = 1'b1;
            if (c == 10) cnt10 = run_cnt;
            if (c == 13) busy13 = busy;
            if (c == 14) busy14 = busy;
        end
        n_tests++;
        if (!ok || cnt10 !== 32'd1) begin
            n_fail++;
            $display("FAIL drop_completes: got run_cnt %0d expected 1", cnt10);
        end
        n_tests++;
        if (busy13 !== 1'b1 || busy14 !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_gap_end: got busy %b%b expected 10", busy13, busy14);
        end
        n_tests++;
        if (restarted) begin
            n_fail++;
            $display("FAIL drop_no_restart: got restart 1 expected 0");
        end
    endtask

    task automatic test_reset_midrun;
        bit ok;
        do_reset();
        set_kernel(1, 9, 1'b0);
        run_en = 1'b1;
        wait_start(ok);
        repeat (32) tick();
        n_tests++;
        if (!ok || run_cnt !== 32'd2 || dataset_idx !== 2'd1 || {busy, ap_start} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_pre: got run_cnt %0d idx %0d busy/start %b expected 2 1 10",
                     run_cnt, dataset_idx, {busy, ap_start});
        end
        n_tests++;
        if (last_lat !== (c_prof ? 32'd10 : 32'd0) || max_lat !== (c_prof ? 32'd10 : 32'd0)) begin
            n_fail++;
            $display("FAIL rst_pre_lat: got %0d/%0d expected %0d", last_lat, max_lat, c_prof ? 10 : 0);
        end
        ap_rst = 1'b1;
        tick();
        n_tests++;
        if ({ap_start, busy, dataset_swap, timeout_err} !== 4'b0000 || run_cnt !== 32'd0 ||
            dataset_idx !== 2'd0 || {last_lat, max_lat} !== 64'd0) begin
            n_fail++;
            $display("FAIL rst_mid: got flags %b run_cnt %0d idx %0d lat %0d/%0d expected all 0",
                     {ap_start, busy, dataset_swap, timeout_err}, run_cnt, dataset_idx, last_lat, max_lat);
        end
        ap_rst = 1'b0;
        run_en = 1'b0;
        tick();
    endtask

    initial begin
        ap_rst = 1'b1;
        run_en = 1'b0;
        test_reset();
        test_single_run();
        test_rotation();
        test_coincident();
        test_done_no_ready();
        test_watchdog();
        test_wd_boundary();
        test_run_en_drop();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
